mux_scan_ctrl: RTL and testbench

- Sequential channel scanner that sits directly upstream of the team's 4:1 single-bit mux.
- Drives the mux select lines S0/S1, walks through the enabled channels with a settle delay and a programmable dwell, and captures the mux output O once per channel.
- Turns the purely combinational mux into a scanned 4-input sampler with start/stop control and per-sample handshake pulses.

---
 rtl/mux_scan_pkg.sv | 12 +
 rtl/mux_scan_next.sv | 31 +++
 rtl/mux_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux channel scanner.
package mux_scan_pkg;
   localparam int CH_W   = 2;
   localparam int NUM_CH = 4;

   localparam logic [CH_W-1:0] CH_A = 2'd0;
   localparam logic [CH_W-1:0] CH_B = 2'd1;
   localparam logic [CH_W-1:0] CH_C = 2'd2;
   localparam logic [CH_W-1:0] CH_D = 2'd3;

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;
endpackage

// File: rtl/mux_scan_next.sv
// Channel search: next enabled channel above ch_i, and lowest enabled channel.
module mux_scan_next
   import mux_scan_pkg::*;
(
   input  logic [NUM_CH-1:0] mask_i,
   input  logic [CH_W-1:0]   ch_i,
   output logic [CH_W-1:0]   nxt_ch_o,
   output logic              found_o,
   output logic [CH_W-1:0]   low_ch_o
);

   always_comb begin
      found_o  = 1'b0;
      nxt_ch_o = ch_i;
      // Descending walk so the closest higher channel is the last one taken.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_i[i] && (i > int'(ch_i))) begin
            found_o  = 1'b1;
            nxt_ch_o = CH_W'(i);
         end
      end
   end

   always_comb begin
      if (mask_i[CH_A])      low_ch_o = CH_A;
      else if (mask_i[CH_B]) low_ch_o = CH_B;
      else if (mask_i[CH_C]) low_ch_o = CH_C;
      else                   low_ch_o = CH_D;
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled inputs of a 4:1 mux: drive select, settle, dwell, capture O.
module mux_scan_ctrl
   import mux_scan_pkg::state_e, mux_scan_pkg::IDLE, mux_scan_pkg::HOLD,
          mux_scan_pkg::CH_W, mux_scan_pkg::NUM_CH;
#(
   parameter int DWELL_W = 8,
   parameter int SETTLE  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               continuous,
   input  logic [NUM_CH-1:0]  en_mask,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               O,
   output logic               S0,
   output logic               S1,
   output logic [CH_W-1:0]    ch,
   output logic [NUM_CH-1:0]  sample,
   output logic               valid,
   output logic               done,
   output logic               busy
);

   localparam int SET_W = $clog2(SETTLE + 1);
   localparam int CNT_W = (DWELL_W > SET_W) ? DWELL_W : SET_W;
   localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   state_e             state_q, state_d;
   logic [CH_W-1:0]    sel_q, sel_d, rep_q, rep_d;
   logic [NUM_CH-1:0]  mask_q, mask_d, smp_q, smp_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               cont_q, cont_d;
   logic               valid_q, valid_d, done_q, done_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, dwell_cnt;

   logic [NUM_CH-1:0]  scan_mask;
   logic [CH_W-1:0]    nxt_ch, low_ch;
   logic               nxt_found;

   // In IDLE the search looks at the live mask so start can pick the first channel.
   assign scan_mask = (state_q == IDLE) ? en_mask : mask_q;
   assign dwell_cnt = (dwell_q == '0) ? ONE : CNT_W'(dwell_q);

   mux_scan_next u_next (
      .mask_i   (scan_mask),
      .ch_i     (sel_q),
      .nxt_ch_o (nxt_ch),
      .found_o  (nxt_found),
      .low_ch_o (low_ch)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      rep_d   = rep_q;
      mask_d  = mask_q;
      smp_d   = smp_q;
      dwell_d = dwell_q;
      cont_d  = cont_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !stop && (en_mask != '0)) begin
               mask_d  = en_mask;
               dwell_d = dwell;
               cont_d  = continuous;
               sel_d   = low_ch;
               cnt_d   = SETTLE_CNT;
               state_d = mux_scan_pkg::SETTLE;
            end
         end
         mux_scan_pkg::SETTLE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (cnt_q == ONE) begin
               cnt_d   = dwell_cnt;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         HOLD: begin
            if (stop) begin
               state_d = IDLE;
            end else if (cnt_q == ONE) begin
               smp_d[sel_q] = O;
               valid_d      = 1'b1;
               rep_d        = sel_q;
               if (nxt_found || cont_q) begin
                  sel_d   = nxt_found ? nxt_ch : low_ch;
                  cnt_d   = SETTLE_CNT;
                  state_d = mux_scan_pkg::SETTLE;
               end else begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         rep_q   <= '0;
         mask_q  <= '0;
         smp_q   <= '0;
         dwell_q <= '0;
         cont_q  <= 1'b0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         rep_q   <= rep_d;
         mask_q  <= mask_d;
         smp_q   <= smp_d;
         dwell_q <= dwell_d;
         cont_q  <= cont_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   // Selects already point at the next channel during the valid cycle; ch reports the sampled one.
   assign S0     = sel_q[1];
   assign S1     = sel_q[0];
   assign ch     = valid_q ? rep_q : sel_q;
   assign sample = smp_q;
   assign valid  = valid_q;
   assign done   = done_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl against a per-cycle timing model of the scan.
module tb_mux_scan_ctrl;
   localparam int DWELL_W = 8;
   localparam int SETTLE  = 2;

   logic               clk = 1'b0;
   logic               rst, start, stop, continuous, O;
   logic [3:0]         en_mask;
   logic [DWELL_W-1:0] dwell;
   logic               S0, S1, valid, done, busy;
   logic [1:0]         ch;
   logic [3:0]         sample;

   logic [3:0] mux_in     = 4'b0000;
   logic [3:0] exp_sample = 4'b0000;
   logic [1:0] cur_sel    = 2'd0;
   int checks = 0;
   int passed = 0;

   assign O = mux_in[{S0, S1}];
   always #5 clk = ~clk;

   mux_scan_ctrl #(.DWELL_W(DWELL_W), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
      .en_mask(en_mask), .dwell(dwell), .O(O), .S0(S0), .S1(S1), .ch(ch),
      .sample(sample), .valid(valid), .done(done), .busy(busy)
   );

   // Edge t counts from the edge that accepts start; channel k owns edges k*P..(k+1)*P.
   task automatic run_scan(input logic [3:0] m, input logic [7:0] dw, input logic c,
                           input int n_edges, input int stop_edge, input bit tog_d,
                           input bit hold_start, input string tag);
      int chans[$];
      int n, p, k, r, vch;
      logic [1:0] e_sel, e_ch, stop_sel;
      logic e_valid, e_done, e_busy;
      logic [10:0] act, expv;
      for (int i = 0; i < 4; i++) if (m[i]) chans.push_back(i);
      n = chans.size();
      p = SETTLE + ((dw == 0) ? 1 : int'(dw));
      stop_sel = cur_sel;
      e_sel = cur_sel;
      @(negedge clk);
      start = 1'b1; stop = 1'b0; en_mask = m; dwell = dw; continuous = c;
      for (int t = 0; t <= n_edges; t++) begin
         @(negedge clk);
         k = t / p;
         r = t % p;
         if (stop_edge >= 0 && t > stop_edge) begin
            e_valid = 1'b0; e_done = 1'b0; e_busy = 1'b0;
            e_sel = stop_sel; e_ch = stop_sel;
         end else begin
            e_valid = (t > 0) && (r == 0) && (c || t <= n * p);
            e_done  = !c && (t == n * p);
            e_busy  = c || (t < n * p);
            e_sel   = c ? 2'(chans[k % n]) : 2'(chans[(k < n) ? k : n - 1]);
            e_ch    = e_sel;
            if (e_valid) begin
               vch = chans[(k - 1) % n];
               e_ch = 2'(vch);
               exp_sample[vch] = mux_in[vch];
            end
            stop_sel = e_sel;
         end
         act  = {valid, done, busy, S0, S1, ch, sample};
         expv = {e_valid, e_done, e_busy, e_sel[1], e_sel[0], e_ch, exp_sample};
         checks++;
         if (act !== expv)
            $display("FAIL %s t=%0d: got v/d/b=%b%b%b sel=%b%b ch=%0d smp=%b, want v/d/b=%b%b%b sel=%b ch=%0d smp=%b",
                     tag, t, valid, done, busy, S0, S1, ch, sample,
                     e_valid, e_done, e_busy, e_sel, e_ch, exp_sample);
         else passed++;
         if (t == 0 && !hold_start) start = 1'b0;
         if (hold_start && t == 0) begin en_mask = 4'b0001; dwell = 8'd9; end
         if (hold_start && t == n * p - 1) start = 1'b0;
         if (stop_edge >= 0) stop = (t == stop_edge);
         if (tog_d && e_valid) mux_in[3] = ~mux_in[3];
      end
      cur_sel = e_sel;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
      en_mask = 4'b0000; dwell = '0;
      #2;
      checks++;
      if ({valid, done, busy, S0, S1, ch, sample} !== 11'b0)
         $display("FAIL reset: got v/d/b=%b%b%b sel=%b%b ch=%0d smp=%b, want all zero",
                  valid, done, busy, S0, S1, ch, sample);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_full_pass();
      mux_in = 4'b1010;
      run_scan(4'b1111, 8'd3, 1'b0, 22, -1, 1'b0, 1'b0, "full_pass");
      checks++;
      if (sample !== 4'b1010) $display("FAIL full_pass_final: got %b, want 1010", sample);
      else passed++;
   endtask

   task automatic test_sparse();
      mux_in = 4'b1111;
      run_scan(4'b1111, 8'd1, 1'b0, 14, -1, 1'b0, 1'b0, "sparse_preset");
      mux_in = 4'b0000;
      run_scan(4'b0101, 8'd0, 1'b0, 8, -1, 1'b0, 1'b0, "sparse");
      checks++;
      if (sample !== 4'b1010) $display("FAIL sparse_final: got %b, want 1010", sample);
      else passed++;
   endtask

   task automatic test_continuous_stop();
      mux_in = 4'b0000;
      run_scan(4'b1000, 8'd0, 1'b1, 14, 8, 1'b1, 1'b0, "cont_stop");
   endtask

   task automatic test_empty_mask();
      @(negedge clk);
      start = 1'b1; en_mask = 4'b0000; dwell = 8'd2; continuous = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ({valid, done, busy, S0, S1, ch, sample} !== {3'b000, cur_sel, cur_sel, exp_sample})
            $display("FAIL empty_mask c=%0d: got v/d/b=%b%b%b sel=%b%b ch=%0d, want 000 sel=%b",
                     i, valid, done, busy, S0, S1, ch, cur_sel);
         else passed++;
      end
   endtask

   task automatic test_ignored_inputs();
      mux_in = 4'($urandom_range(0, 15));
      run_scan(4'b0110, 8'd2, 1'b0, 10, -1, 1'b0, 1'b1, "ignored");
      en_mask = 4'b0000;
   endtask

   task automatic test_random();
      logic [3:0] m;
      logic [7:0] dw;
      int p;
      for (int i = 0; i < 4; i++) begin
         m  = 4'($urandom_range(1, 15));
         dw = 8'($urandom_range(0, 4));
         mux_in = 4'($urandom_range(0, 15));
         p = SETTLE + ((dw == 0) ? 1 : int'(dw));
         run_scan(m, dw, 1'b0, $countones(m) * p + 2, -1, 1'b0, 1'b0, "random");
      end
   endtask

   task automatic test_async_reset();
      run_scan(4'b0110, 8'd4, 1'b1, 4, -1, 1'b0, 1'b0, "pre_reset");
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({valid, done, busy, S0, S1, ch, sample} !== 11'b0)
         $display("FAIL async_reset: got v/d/b=%b%b%b sel=%b%b ch=%0d smp=%b, want all zero",
                  valid, done, busy, S0, S1, ch, sample);
      else passed++;
      #2 rst = 1'b0;
      exp_sample = 4'b0000;
      cur_sel = 2'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({valid, done, busy, S0, S1, ch, sample} !== 11'b0)
            $display("FAIL post_reset_idle c=%0d: got v/d/b=%b%b%b ch=%0d smp=%b, want all zero",
                     i, valid, done, busy, ch, sample);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_full_pass();
      test_sparse();
      test_continuous_stop();
      test_empty_mask();
      test_ignored_inputs();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
